// File: rtl/ysyx_23060203_lsu.sv
// rtl/ysyx_23060203_lsu.sv - load/store stage with AXI4-Lite-style master port
module ysyx_23060203_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [3:0]  in_gpr_waddr,
  input  logic [31:0] in_gpr_wdata,
  input  logic        in_mem_ren,
  input  logic        in_mem_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_mem_addr,
  input  logic [31:0] in_mem_wdata,
  input  logic        in_csr_wen,
  input  logic [11:0] in_csr_waddr,
  input  logic [31:0] in_csr_wdata,
  input  logic        in_exc,
  input  logic        in_ret,
  input  logic        in_fencei,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_gpr_waddr,
  output logic [31:0] out_gpr_wdata,
  output logic        out_csr_wen,
  output logic [11:0] out_csr_waddr,
  output logic [31:0] out_csr_wdata,
  output logic        out_exc,
  output logic        out_ret,
  output logic        out_fencei,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        in_fire;
  logic        aw_ok;
  logic        w_ok;
  logic [31:0] raw;
  logic [31:0] load_data;
  logic [3:0]  strb_base;
  logic        unused_resp;

  // DONE accepts a new instruction while its result drains, giving 1/cycle ALU throughput
  assign in_ready    = (state == IDLE || state == DONE) && (!out_valid || out_ready);
  assign in_fire     = in_valid && in_ready;
  assign aw_ok       = !awvalid || awready;
  assign w_ok        = !wvalid || wready;
  assign araddr      = addr_q;
  assign awaddr      = addr_q;
  assign unused_resp = ^{rresp, bresp};

  assign raw = rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{raw[7] & ~funct3_q[2]}}, raw[7:0]};
      2'b01:   load_data = {{16{raw[15] & ~funct3_q[2]}}, raw[15:0]};
      default: load_data = raw;
    endcase
  end

  always_comb begin
    case (in_funct3[1:0])
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (in_fire) begin
          if (in_mem_ren)      state_n = AR;
          else if (in_mem_wen) state_n = WR;
          else                 state_n = DONE;
        end else if (state == DONE && out_ready) begin
          state_n = IDLE;
        end
      end
      AR:      if (arready) state_n = R;
      R:       if (rvalid) state_n = DONE;
      WR:      if (aw_ok && w_ok) state_n = B;
      B:       if (bvalid) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      arvalid   <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      rready    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (in_fire) begin
            out_valid <= !in_mem_ren && !in_mem_wen;
            arvalid   <= in_mem_ren;
            awvalid   <= in_mem_wen && !in_mem_ren;
            wvalid    <= in_mem_wen && !in_mem_ren;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        AR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
        end
        R: if (rvalid) begin
          rready    <= 1'b0;
          out_valid <= 1'b1;
        end
        WR: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if (aw_ok && w_ok) bready <= 1'b1;
        end
        B: if (bvalid) begin
          bready    <= 1'b0;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Payload registers carry no reset; their contents are don't-care until out_valid
  always_ff @(posedge clock) begin
    if (in_fire) begin
      out_pc        <= in_pc;
      out_gpr_waddr <= in_gpr_waddr;
      out_gpr_wdata <= in_gpr_wdata;
      out_csr_wen   <= in_csr_wen;
      out_csr_waddr <= in_csr_waddr;
      out_csr_wdata <= in_csr_wdata;
      out_exc       <= in_exc;
      out_ret       <= in_ret;
      out_fencei    <= in_fencei;
      addr_q        <= in_mem_addr;
      funct3_q      <= in_funct3;
      wdata         <= in_mem_wdata << {in_mem_addr[1:0], 3'b000};
      wstrb         <= strb_base << in_mem_addr[1:0];
    end else if (state == R && rvalid) begin
      out_gpr_wdata <= load_data;
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// tb/tb_ysyx_23060203_lsu.sv - randomized self-checking bench for the LSU
module tb_ysyx_23060203_lsu;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_gpr_wdata, in_mem_addr, in_mem_wdata, in_csr_wdata;
  logic [3:0]  in_gpr_waddr;
  logic        in_mem_ren, in_mem_wen, in_csr_wen, in_exc, in_ret, in_fencei;
  logic [2:0]  in_funct3;
  logic [11:0] in_csr_waddr;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_gpr_wdata, out_csr_wdata;
  logic [3:0]  out_gpr_waddr;
  logic        out_csr_wen, out_exc, out_ret, out_fencei;
  logic [11:0] out_csr_waddr;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  ysyx_23060203_lsu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
    .in_mem_addr(in_mem_addr), .in_mem_wdata(in_mem_wdata),
    .in_csr_wen(in_csr_wen), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
    .in_exc(in_exc), .in_ret(in_ret), .in_fencei(in_fencei),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_gpr_waddr(out_gpr_waddr), .out_gpr_wdata(out_gpr_wdata),
    .out_csr_wen(out_csr_wen), .out_csr_waddr(out_csr_waddr), .out_csr_wdata(out_csr_wdata),
    .out_exc(out_exc), .out_ret(out_ret), .out_fencei(out_fencei),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc, exp_csr_wdata, exp_misc;
  logic [31:0] addr, data, word;
  logic [2:0]  f3;
  int          kind, d0, d1, d2, bp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [2:0] fn);
    return (fn[1:0] == 2'd0) ? 32'd1 : (fn[1:0] == 2'd1) ? 32'd2 : 32'd4;
  endfunction

  // Reference: pick the addressed bytes out of the word, then sign/zero extend arithmetically
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] fn, input logic [31:0] w);
    longint unsigned v;
    int unsigned     n;
    n = nbytes(fn);
    v = (64'(w) >> (8 * (a % 4))) % (64'd1 << (8 * n));
    if (!fn[2] && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [2:0] fn);
    int unsigned m;
    m = ((32'd1 << nbytes(fn)) - 32'd1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] a, input logic [31:0] d);
    longint unsigned v;
    v = (64'(d) << (8 * (a % 4))) & 64'hFFFF_FFFF;
    return v[31:0];
  endfunction

  task automatic issue(input logic ren, input logic wen, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] md, input logic [31:0] alu);
    in_valid     = 1'b1;
    in_pc        = $urandom;
    in_gpr_waddr = wen && !ren ? 4'd0 : 4'($urandom);
    in_gpr_wdata = alu;
    in_mem_ren   = ren;
    in_mem_wen   = wen;
    in_funct3    = fn;
    in_mem_addr  = a;
    in_mem_wdata = md;
    in_csr_wen   = 1'($urandom);
    in_csr_waddr = 12'($urandom);
    in_csr_wdata = $urandom;
    in_exc       = 1'($urandom);
    in_ret       = 1'($urandom);
    in_fencei    = 1'($urandom);
    exp_pc        = in_pc;
    exp_csr_wdata = in_csr_wdata;
    exp_misc      = {in_csr_waddr, 12'd0, in_csr_wen, in_exc, in_ret, in_fencei, in_gpr_waddr};
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_pc"}, out_pc, exp_pc);
    check({tag, "_csr_wdata"}, out_csr_wdata, exp_csr_wdata);
    check({tag, "_misc"}, {out_csr_waddr, 12'd0, out_csr_wen, out_exc, out_ret, out_fencei, out_gpr_waddr}, exp_misc);
  endtask

  // Hold the result under backpressure with a load waiting upstream, then release it
  task automatic drain(input int n, input logic chk, input logic [31:0] exp, input string tag);
    for (int k = 0; k < n; k++) begin
      in_valid   = 1'b1;
      in_mem_ren = 1'b1;
      in_mem_wen = 1'b0;
      in_pc      = ~exp_pc;
      check1({tag, "_bp_out_valid"}, out_valid, 1'b1);
      check1({tag, "_bp_in_ready"}, in_ready, 1'b0);
      check1({tag, "_bp_arvalid"}, arvalid, 1'b0);
      check1({tag, "_bp_awvalid"}, awvalid, 1'b0);
      check({tag, "_bp_pc"}, out_pc, exp_pc);
      if (chk) check({tag, "_bp_wdata"}, out_gpr_wdata, exp);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check1({tag, "_drained"}, out_valid, 1'b0);
    check1({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  task automatic do_alu(input logic [31:0] v, input int n, input string tag);
    issue(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, v);
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    check1({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_wdata"}, out_gpr_wdata, v);
    check_fields(tag);
    drain(n, 1'b1, v, tag);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] fn, input logic [31:0] w,
                         input int ar_d, input int r_d, input int n, input logic also_wen,
                         input logic [31:0] exp, input string tag);
    issue(1'b1, also_wen, fn, a, $urandom, $urandom);
    arready = 1'b0;
    rvalid  = 1'b0;
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    for (int k = 0; k <= ar_d; k++) begin
      check1({tag, "_arvalid"}, arvalid, 1'b1);
      check({tag, "_araddr"}, araddr, a);
      check1({tag, "_ar_rready"}, rready, 1'b0);
      check1({tag, "_ar_awvalid"}, awvalid, 1'b0);
      check1({tag, "_ar_out_valid"}, out_valid, 1'b0);
      arready = (k == ar_d);
      @(negedge clock);
    end
    arready = 1'b0;
    check1({tag, "_ar_dropped"}, arvalid, 1'b0);
    for (int k = 0; k < r_d; k++) begin
      rdata = $urandom;
      check1({tag, "_r_wait_rready"}, rready, 1'b1);
      check1({tag, "_r_wait_out_valid"}, out_valid, 1'b0);
      @(negedge clock);
    end
    check1({tag, "_rready"}, rready, 1'b1);
    rdata  = w;
    rvalid = 1'b1;
    @(negedge clock);
    rvalid = 1'b0;
    rdata  = $urandom;
    check1({tag, "_out_valid"}, out_valid, 1'b1);
    check1({tag, "_rready_low"}, rready, 1'b0);
    check({tag, "_data"}, out_gpr_wdata, exp);
    check_fields(tag);
    drain(n, 1'b1, exp, tag);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] fn, input logic [31:0] d,
                          input int aw_d, input int w_d, input int b_d, input int n,
                          input logic [31:0] exp_wd, input logic [3:0] exp_st, input string tag);
    logic aw_p, w_p;
    issue(1'b0, 1'b1, fn, a, d, $urandom);
    check1({tag, "_in_ready"}, in_ready, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    aw_p = 1'b1;
    w_p  = 1'b1;
    for (int c = 0; c < 8 && (aw_p || w_p); c++) begin
      awready = (c >= aw_d);
      wready  = (c >= w_d);
      check1({tag, "_awvalid"}, awvalid, aw_p);
      check1({tag, "_wvalid"}, wvalid, w_p);
      check1({tag, "_early_bready"}, bready, 1'b0);
      check1({tag, "_wr_out_valid"}, out_valid, 1'b0);
      if (aw_p) check({tag, "_awaddr"}, awaddr, a);
      if (w_p) check({tag, "_wdata"}, wdata, exp_wd);
      if (w_p) check({tag, "_wstrb"}, 32'(wstrb), 32'(exp_st));
      @(negedge clock);
      if (awready) aw_p = 1'b0;
      if (wready) w_p = 1'b0;
    end
    awready = 1'b0;
    wready  = 1'b0;
    for (int k = 0; k <= b_d; k++) begin
      check1({tag, "_bready"}, bready, 1'b1);
      check1({tag, "_b_awvalid"}, awvalid, 1'b0);
      check1({tag, "_b_wvalid"}, wvalid, 1'b0);
      check1({tag, "_b_out_valid"}, out_valid, 1'b0);
      bresp  = 2'($urandom);
      bvalid = (k == b_d);
      @(negedge clock);
    end
    bvalid = 1'b0;
    check1({tag, "_out_valid"}, out_valid, 1'b1);
    check1({tag, "_bready_low"}, bready, 1'b0);
    check_fields(tag);
    drain(n, 1'b0, 32'd0, tag);
  endtask

  initial begin
    in_valid = 1'b0; in_pc = 32'd0; in_gpr_waddr = 4'd0; in_gpr_wdata = 32'd0;
    in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_funct3 = 3'd0; in_mem_addr = 32'd0;
    in_mem_wdata = 32'd0; in_csr_wen = 1'b0; in_csr_waddr = 12'd0; in_csr_wdata = 32'd0;
    in_exc = 1'b0; in_ret = 1'b0; in_fencei = 1'b0; out_ready = 1'b0;
    arready = 1'b0; rdata = 32'd0; rresp = 2'd0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'd0; bvalid = 1'b0;

    repeat (2) @(negedge clock);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_arvalid", arvalid, 1'b0);
    check1("rst_awvalid", awvalid, 1'b0);
    check1("rst_wvalid", wvalid, 1'b0);
    check1("rst_rready", rready, 1'b0);
    check1("rst_bready", bready, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check1("post_rst_in_ready", in_ready, 1'b1);

    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      issue(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'(i));
      check1("stream_in_ready", in_ready, 1'b1);
      @(negedge clock);
      check1("stream_out_valid", out_valid, 1'b1);
      check("stream_wdata", out_gpr_wdata, 32'(i));
      check_fields("stream");
    end
    in_valid = 1'b0;
    @(negedge clock);
    check1("stream_end_valid", out_valid, 1'b0);
    check1("stream_end_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    do_load(32'h8000_0003, 3'b000, 32'h80FF_FF7F, 0, 0, 0, 1'b0, 32'hFFFF_FF80, "lb");
    do_load(32'h8000_0003, 3'b100, 32'h80FF_FF7F, 0, 0, 0, 1'b0, 32'h0000_0080, "lbu");
    do_load(32'h8000_0002, 3'b001, 32'h80FF_FF7F, 0, 0, 0, 1'b0, 32'hFFFF_80FF, "lh");
    do_load(32'h8000_0002, 3'b101, 32'h80FF_FF7F, 0, 1, 0, 1'b0, 32'h0000_80FF, "lhu");
    do_load(32'h8000_0000, 3'b010, 32'h80FF_FF7F, 0, 0, 0, 1'b0, 32'h80FF_FF7F, "lw");
    do_load(32'h8000_0000, 3'b010, 32'h1357_9BDF, 0, 0, 0, 1'b1, 32'h1357_9BDF, "ren_wen");
    do_load(32'h8000_0010, 3'b010, 32'hCAFE_F00D, 5, 2, 0, 1'b0, 32'hCAFE_F00D, "ar_skew");
    do_load(32'h8000_0021, 3'b000, 32'h0000_7F00, 0, 0, 4, 1'b0, 32'h0000_007F, "backpressure");

    do_store(32'h8000_0001, 3'b000, 32'h1234_5678, 0, 0, 0, 0, 32'h3456_7800, 4'b0010, "sb");
    do_store(32'h8000_0002, 3'b001, 32'h1234_5678, 0, 0, 0, 0, 32'h5678_0000, 4'b1100, "sh");
    do_store(32'h8000_0004, 3'b010, 32'hA5A5_0F0F, 3, 0, 1, 0, 32'hA5A5_0F0F, 4'b1111, "aw_skew");
    do_store(32'h8000_0003, 3'b000, 32'h0000_00EE, 0, 2, 0, 2, 32'hEE00_0000, 4'b1000, "w_skew");

    issue(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'd0, 32'd0);
    arready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    arready = 1'b0;
    check1("rst_in_r_rready_before", rready, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check1("rst_in_r_rready", rready, 1'b0);
    check1("rst_in_r_out_valid", out_valid, 1'b0);
    check1("rst_in_r_arvalid", arvalid, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check1("rst_in_r_in_ready", in_ready, 1'b1);
    do_load(32'h8000_0041, 3'b100, 32'h0000_9C00, 1, 0, 0, 1'b0, 32'h0000_009C, "after_rst");

    for (int it = 0; it < 24; it++) begin
      kind = $urandom_range(0, 2);
      d0   = $urandom_range(0, 3);
      d1   = $urandom_range(0, 3);
      d2   = $urandom_range(0, 3);
      bp   = $urandom_range(0, 2);
      data = $urandom;
      word = $urandom;
      addr = $urandom;
      if (kind == 0) begin
        do_alu(data, bp, "rnd_alu");
      end else if (kind == 1) begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 == 3'd3) f3 = 3'd4;
        addr = addr & ~(nbytes(f3) - 32'd1);
        do_load(addr, f3, word, d0, d1, bp, 1'b0, model_load(addr, f3, word), "rnd_load");
      end else begin
        f3 = 3'($urandom_range(0, 2));
        addr = addr & ~(nbytes(f3) - 32'd1);
        do_store(addr, f3, data, d0, d1, d2, bp, model_wdata(addr, data), model_strb(addr, f3), "rnd_store");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule
